// File: rtl/control_jugador.sv
// Player sprite position sequencer: once per frame, at the start of vertical blanking,
// samples the buttons and publishes a clamped position. Optional macro: CONTROL_ACEL_EN.
module control_jugador #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int X_MIN   = 100,
  parameter int X_MAX   = 540,
  parameter int ANCHO   = 100,
  parameter int ALTO    = 124,
`ifdef CONTROL_ACEL_EN
  parameter int VEL_MAX = 4,
`else
  parameter int PASO    = 2,
`endif
  parameter int X_INI   = 300,
  parameter int Y_INI   = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixelX,
  input  logic [9:0]  pixelY,
  input  logic        habilitar,
  input  logic        btn_izq,
  input  logic        btn_der,
  input  logic        btn_arr,
  input  logic        btn_abj,
  output logic [19:0] posicionJugador,
  output logic        actualizado,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    MUESTREO  = 2'd1,
    CALCULO   = 2'd2,
    ESCRITURA = 2'd3
  } estado_e;

  localparam int X_DER = ((X_MAX < H_ACT) ? X_MAX : H_ACT) - ANCHO;
  localparam logic signed [10:0] X_LO = 11'(X_MIN);
  localparam logic signed [10:0] X_HI = 11'(X_DER);
  localparam logic signed [10:0] Y_LO = 11'sd0;
  localparam logic signed [10:0] Y_HI = 11'(V_ACT - ALTO);

  // Button vectors are ordered {abj, arr, der, izq}.
  logic [3:0] sync1_q, sync2_q, btn_q;
  logic       fin_q, fin_prev_q;
  logic       disparo;
  estado_e    state_q, state_d;
  logic [9:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic       actualizado_q;

  logic signed [10:0] step_x, step_y, tgt_x, tgt_y;

  function automatic logic [9:0] recortar(input logic signed [10:0] t,
                                          input logic signed [10:0] lo,
                                          input logic signed [10:0] hi);
    if (t <= lo)      return lo[9:0];
    else if (t >= hi) return hi[9:0];
    else              return t[9:0];
  endfunction

  // NOTE: every flop is written with <= so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      fin_q      <= 1'b0;
      fin_prev_q <= 1'b0;
      state_q    <= ESPERA;
    end else begin
      sync1_q    <= {btn_abj, btn_arr, btn_der, btn_izq};
      sync2_q    <= sync1_q;
      fin_q      <= (pixelY == 10'(V_ACT)) && (pixelX == 10'd0);
      fin_prev_q <= fin_q;
      state_q    <= state_d;
    end
  end

  // One trigger per frame no matter how many clocks the first blanking pixel lasts.
  assign disparo = fin_q && !fin_prev_q;

  // NOTE: defaults first so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ESPERA:    if (disparo && habilitar) state_d = MUESTREO;
      MUESTREO:  state_d = CALCULO;
      CALCULO:   state_d = ESCRITURA;
      ESCRITURA: state_d = ESPERA;
      default:   state_d = ESPERA;
    endcase
  end

`ifdef CONTROL_ACEL_EN
  localparam int VW = $clog2(VEL_MAX + 1) + 1;
  localparam logic signed [10:0] VMAX = 11'(VEL_MAX);

  logic signed [VW-1:0] vel_x_q, vel_y_q, vel_x_d, vel_y_d;
  logic signed [10:0]   vel_x_ext, vel_y_ext;

  assign vel_x_ext = {{(11-VW){vel_x_q[VW-1]}}, vel_x_q};
  assign vel_y_ext = {{(11-VW){vel_y_q[VW-1]}}, vel_y_q};

  // Ramps up while one direction is held, restarts at 1 on reversal, stops otherwise.
  function automatic logic signed [10:0] vel_nueva(input logic neg,
                                                   input logic pos,
                                                   input logic signed [10:0] v);
    if (pos && !neg) begin
      if (v < 0)          return 11'sd1;
      else if (v >= VMAX) return VMAX;
      else                return v + 11'sd1;
    end else if (neg && !pos) begin
      if (v > 0)           return -11'sd1;
      else if (v <= -VMAX) return -VMAX;
      else                 return v - 11'sd1;
    end
    return 11'sd0;
  endfunction

  always_comb begin
    step_x  = vel_nueva(btn_q[0], btn_q[1], vel_x_ext);
    step_y  = vel_nueva(btn_q[2], btn_q[3], vel_y_ext);
    tgt_x   = $signed({1'b0, pos_x_q}) + step_x;
    tgt_y   = $signed({1'b0, pos_y_q}) + step_y;
    pos_x_d = recortar(tgt_x, X_LO, X_HI);
    pos_y_d = recortar(tgt_y, Y_LO, Y_HI);
    // Reaching a road or screen edge kills the momentum on that axis.
    vel_x_d = ((tgt_x <= X_LO) || (tgt_x >= X_HI)) ? '0 : step_x[VW-1:0];
    vel_y_d = ((tgt_y <= Y_LO) || (tgt_y >= Y_HI)) ? '0 : step_y[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_x_q <= '0;
      vel_y_q <= '0;
    end else if (state_q == CALCULO) begin
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
    end else if (state_q == ESPERA && !habilitar) begin
      vel_x_q <= '0;
      vel_y_q <= '0;
    end
  end
`else
  localparam logic signed [10:0] PASO_S = 11'(PASO);

  function automatic logic signed [10:0] paso_fijo(input logic neg, input logic pos);
    if (pos && !neg)      return PASO_S;
    else if (neg && !pos) return -PASO_S;
    else                  return 11'sd0;
  endfunction

  always_comb begin
    step_x  = paso_fijo(btn_q[0], btn_q[1]);
    step_y  = paso_fijo(btn_q[2], btn_q[3]);
    tgt_x   = $signed({1'b0, pos_x_q}) + step_x;
    tgt_y   = $signed({1'b0, pos_y_q}) + step_y;
    pos_x_d = recortar(tgt_x, X_LO, X_HI);
    pos_y_d = recortar(tgt_y, Y_LO, Y_HI);
  end
`endif

  // Position loads on the edge into ESCRITURA, so it and the pulse are visible in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q         <= '0;
      pos_x_q       <= 10'(X_INI);
      pos_y_q       <= 10'(Y_INI);
      actualizado_q <= 1'b0;
    end else begin
      if (state_q == MUESTREO) btn_q <= sync2_q;
      if (state_q == CALCULO) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
      end
      actualizado_q <= (state_q == CALCULO);
    end
  end

  assign posicionJugador = {pos_y_q, pos_x_q};
  assign actualizado     = actualizado_q;
  assign estado          = state_q;

endmodule

// File: tb/tb_control_jugador.sv
// Self-checking bench for control_jugador: directed and random button frames against a
// per-axis behavioural model; honours CONTROL_ACEL_EN the same way the design does.
module tb_control_jugador;

  localparam int V_ACT   = 480;
  localparam int X_LO    = 100;
  localparam int X_HI    = 540 - 100;
  localparam int Y_HI    = 480 - 124;
  localparam int X_INI   = 300;
  localparam int Y_INI   = 300;
  localparam int VEL_MAX = 4;
  localparam int PASO    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixelX, pixelY;
  logic        habilitar, btn_izq, btn_der, btn_arr, btn_abj;
  logic [19:0] posicionJugador;
  logic        actualizado;
  logic [1:0]  estado;

  int checks = 0;
  int errors = 0;

  // Reference model state: position and signed velocity per axis.
  int px, py, vx, vy;

  always #5 clk = ~clk;

  control_jugador dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .habilitar       (habilitar),
    .btn_izq         (btn_izq),
    .btn_der         (btn_der),
    .btn_arr         (btn_arr),
    .btn_abj         (btn_abj),
    .posicionJugador (posicionJugador),
    .actualizado     (actualizado),
    .estado          (estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pack(input int x, input int y);
    logic [9:0] xs, ys;
    xs = 10'(x);
    ys = 10'(y);
    return {ys, xs};
  endfunction

  // One axis, one frame: direction from the buttons, speed from the rules, then clamp.
  task automatic mover(input bit neg, input bit pos, input int lo, input int hi,
                       input int p_in, input int v_in, output int p_out, output int v_out);
    int dir, v, t;
    dir = (pos && !neg) ? 1 : ((neg && !pos) ? -1 : 0);
`ifdef CONTROL_ACEL_EN
    if (dir == 0)             v = 0;
    else if (v_in * dir < 0)  v = dir;
    else                      v = v_in + dir;
    if (v * dir > VEL_MAX)    v = dir * VEL_MAX;
`else
    v = dir * PASO;
`endif
    t = p_in + v;
    if (t <= lo)      begin p_out = lo; v_out = 0; end
    else if (t >= hi) begin p_out = hi; v_out = 0; end
    else              begin p_out = t;  v_out = v; end
  endtask

  task automatic idle_pixel();
    if ($urandom_range(0, 1) == 1) begin
      pixelY = 10'(V_ACT);
      pixelX = 10'($urandom_range(1, 639));
    end else begin
      pixelY = 10'($urandom_range(0, V_ACT - 1));
      pixelX = 10'($urandom_range(0, 639));
    end
  endtask

  // b = {abj, arr, der, izq}; hold = clocks the trigger pixel lasts; drop lowers habilitar mid-sequence.
  task automatic frame(input logic [3:0] b, input bit hab, input int hold, input bit drop);
    int ex, ey, evx, evy, first, pulses;
    @(negedge clk);
    {btn_abj, btn_arr, btn_der, btn_izq} = b;
    habilitar = hab;
    idle_pixel();
    repeat (4) @(negedge clk);
    if (hab) begin
      mover(b[0], b[1], X_LO, X_HI, px, vx, ex, evx);
      mover(b[2], b[3], 0, Y_HI, py, vy, ey, evy);
      if (drop) begin evx = 0; evy = 0; end
    end else begin
      ex = px; ey = py; evx = 0; evy = 0;
    end
    pixelY = 10'(V_ACT);
    pixelX = 10'd0;
    first  = 0;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == hold) idle_pixel();
      if (c == 2 && hab && drop) habilitar = 1'b0;
      if (c == 3) check("estado_mid", 32'(estado), hab ? 32'd2 : 32'd0);
      if (c < 4 && hab) check("pos_before_write", 32'(posicionJugador), 32'(pack(px, py)));
      if (actualizado === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = c;
          check("pos_at_pulse", 32'(posicionJugador), 32'(pack(ex, ey)));
        end
      end
    end
    check("pulse_count", 32'(pulses), hab ? 32'd1 : 32'd0);
    if (hab) check("pulse_latency", 32'(first), 32'd4);
    check("pos_stable", 32'(posicionJugador), 32'(pack(ex, ey)));
    check("estado_idle", 32'(estado), 32'd0);
    px = ex; py = ey; vx = evx; vy = evy;
  endtask

  task automatic reset_in_calculo();
    @(negedge clk);
    {btn_abj, btn_arr, btn_der, btn_izq} = 4'b0010;
    habilitar = 1'b1;
    idle_pixel();
    repeat (4) @(negedge clk);
    pixelY = 10'(V_ACT);
    pixelX = 10'd0;
    @(negedge clk);
    idle_pixel();
    @(negedge clk);
    @(negedge clk);
    check("rst_state_calc", 32'(estado), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_async_pos", 32'(posicionJugador), 32'(pack(X_INI, Y_INI)));
    check("rst_async_act", 32'(actualizado), 32'd0);
    check("rst_async_est", 32'(estado), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_act", 32'(actualizado), 32'd0);
    rst_n = 1'b1;
    px = X_INI; py = Y_INI; vx = 0; vy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_act", 32'(actualizado), 32'd0);
    end
    check("post_rst_pos", 32'(posicionJugador), 32'(pack(X_INI, Y_INI)));
  endtask

  initial begin
    logic [3:0] b;
    rst_n = 1'b0;
    habilitar = 1'b0;
    {btn_abj, btn_arr, btn_der, btn_izq} = 4'b0000;
    pixelY = 10'd0;
    pixelX = 10'd5;
    px = X_INI; py = Y_INI; vx = 0; vy = 0;
    repeat (3) @(negedge clk);
    check("reset_pos", 32'(posicionJugador), 32'(pack(X_INI, Y_INI)));
    check("reset_act", 32'(actualizado), 32'd0);
    check("reset_estado", 32'(estado), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("release_pos", 32'(posicionJugador), 32'(pack(X_INI, Y_INI)));

    for (int i = 0; i < 5; i++) frame(4'b0010, 1'b1, 1 + (i % 4), 1'b0);
    for (int i = 0; i < 3; i++) frame(4'b0011, 1'b1, 2, 1'b0);
    frame(4'b0001, 1'b1, 1, 1'b0);
    for (int i = 0; i < 4; i++) frame(4'b1111, 1'b0, 3, 1'b0);
    frame(4'b1000, 1'b1, 1, 1'b0);
    reset_in_calculo();
    for (int i = 0; i < 2; i++) frame(4'b0010, 1'b1, 1, 1'b0);

    // Long diagonal holds drive both axes into their clamps.
    for (int i = 0; i < 160; i++) frame(4'b0110, 1'b1, 1 + (i % 3), 1'b0);
    for (int i = 0; i < 200; i++) frame(4'b1001, 1'b1, 1 + (i % 4), 1'b0);

    b = 4'b0000;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) < 3) b = 4'($urandom_range(0, 15));
      frame(b, ($urandom_range(0, 9) < 8), $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_jugador.md
Name: control_jugador

Overview:
Sequences the player sprite position that feeds the VGA pixel multiplexer in the memory block. Once per frame, at the start of vertical blanking, it samples the direction buttons, updates per-axis velocity, computes the new position, clamps it to the road, and publishes it as a 20-bit packed position. The position register changes only during blanking, so no frame ever shows a partially updated sprite.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines; blanking starts at pixelY == V_ACT
X_MIN, 100, left road margin (green band is pixelX < X_MIN)
X_MAX, 540, right road margin
ANCHO, 100, sprite width
ALTO, 124, sprite height
X_INI, 300, reset X
Y_INI, 300, reset Y
VEL_MAX, 4, maximum pixels moved per frame per axis
PASO, 2, fixed step used when CONTROL_ACEL_EN is undefined

Ports:
clk  in  1  system clock, same domain as the pixel counters
rst_n  in  1  asynchronous, active-low reset
pixelX  in  10  current scan X
pixelY  in  10  current scan Y
habilitar  in  1  game running; low freezes position
btn_izq  in  1  left button, asynchronous, active-high
btn_der  in  1  right button
btn_arr  in  1  up button
btn_abj  in  1  down button
posicionJugador  out  20  [9:0] = X, [19:10] = Y (top-left corner of sprite)
actualizado  out  1  1-cycle pulse when posicionJugador is written
estado  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst_n = 0): posicionJugador = {Y_INI, X_INI}; actualizado = 0; estado = ESPERA; velocities = 0; synchronizers cleared.
- Buttons: each passes through a 2-flop synchronizer. The FSM uses only the synchronized values.
- Frame trigger: fin_cuadro = (pixelY == V_ACT && pixelX == 0), registered. The trigger fires on the rising edge of that registered value, so exactly once per frame, however many clocks each pixel lasts.
- FSM states: ESPERA=0, MUESTREO=1, CALCULO=2, ESCRITURA=3.
  - ESPERA -> MUESTREO on trigger when habilitar = 1. With habilitar = 0 it stays in ESPERA, holds the position, and zeroes the velocities.
  - MUESTREO (1 cycle): latch the four synchronized buttons.
  - CALCULO (1 cycle): update velocities and compute the clamped target.
  - ESCRITURA (1 cycle): load posicionJugador, assert actualizado, go to ESPERA.
- Latency: trigger at cycle N. The new position is visible and actualizado = 1 at cycle N+3 (the ESCRITURA register output). The position is stable for the rest of the frame.
- Velocity per axis, with CONTROL_ACEL_EN defined:
  - A single direction held: vel = min(vel + 1, VEL_MAX), where vel was 0 or already in the same direction.
  - Reversal: vel restarts at 1 in the new direction.
  - Release, or both opposing buttons pressed: vel = 0 and no move on that axis.
  - Step applied each frame = the updated vel.
- Arithmetic: 11-bit signed intermediate, so there is no 10-bit wrap.
  - X is clamped to [X_MIN, X_MAX - ANCHO] = [100, 440].
  - Y is clamped to [0, V_ACT - ALTO] = [0, 356].
  - Hitting a clamp bound zeroes that axis velocity.
- Axes are independent; diagonal moves are allowed.
- habilitar falling mid-sequence: the current sequence completes, then the FSM holds in ESPERA.
- A trigger arriving while not in ESPERA is ignored; this is impossible in practice because the sequence is 3 cycles per frame.
- rst_n asserted in any state: immediate return to reset values. No write occurs and actualizado stays 0.

Optional Feature:
CONTROL_ACEL_EN
- Defined: the velocity ramp described above (1, 2, ... up to VEL_MAX pixels per frame).
- Undefined: no velocity registers. Each frame, a single held direction moves the sprite exactly PASO pixels; opposing buttons produce no move. The clamp, FSM and latency are identical in both cases.

Test Plan:
1. Reset: rst_n low, then high -> posicionJugador = {300, 300}, actualizado = 0, estado = 0.
2. ACEL on; btn_der held for 5 frames from X = 300 -> X = 301, 303, 306, 310, 314; Y stays 300; one actualizado pulse per frame, 3 cycles after the trigger.
3. Clamp: X = 438, vel 4, btn_der held -> X = 440, then stays 440 on later frames. btn_arr held from Y = 2 -> Y = 0; no wrap to 1023.
4. btn_izq and btn_der together for 3 frames -> X unchanged, X velocity 0. Then btn_izq alone -> X decreases by 1.
5. habilitar = 0 with all buttons held over 4 frames -> position unchanged, no actualizado pulse. Re-enable with btn_abj -> Y = 301.
6. rst_n pulsed low during CALCULO -> position returns to {300, 300} immediately with no actualizado. With ACEL off, btn_der for 2 frames -> X = 302, 304.
